// File: rtl/master_out_port.sv
// Master-side serializer for the serial system bus: latches a parallel request,
// handshakes with the slave, then shifts address and write data out LSB-first.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; all outputs low
// REQ       | master_valid up, waiting for slave_ready handshake
// ADDR      | shifting the address (and first write byte) out, one bit/cycle
// BEAT_WAIT | write burst: waiting for the next beat handshake
// DATA      | write burst: shifting one extra data byte out
// RD_HOLD   | read burst: holding master_valid for the remaining beats
// DONE      | one-cycle tx_done pulse
module master_out_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] addr_in_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic [ADDR_W:0]   burst_i,
  input  logic              slave_ready_i,
  output logic              master_valid_o,
  output logic              tx_addr_o,
  output logic              tx_data_o,
  output logic              data_req_o,
  output logic              busy_o,
  output logic              tx_done_o
);

  localparam int CNT_W  = $clog2(ADDR_W);
  localparam int DIDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0]  LAST_ADDR_BIT = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  LAST_DATA_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  DATA_BITS     = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [ADDR_W-1:0] BEAT_ONE      = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    ADDR      = 3'd2,
    BEAT_WAIT = 3'd3,
    DATA      = 3'd4,
    RD_HOLD   = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                data_req_q, data_req_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      beats_q    <= '0;
      cnt_q      <= '0;
      data_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      data_req_q <= data_req_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    wr_d           = wr_q;
    beats_d        = beats_q;
    cnt_d          = cnt_q;
    data_req_d     = 1'b0;
    master_valid_o = 1'b0;
    tx_addr_o      = 1'b0;
    tx_data_o      = 1'b0;
    tx_done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = addr_in_i;
          data_d  = data_in_i;
          wr_d    = write_en_i;
          beats_d = burst_i[0] ? burst_i[ADDR_W:1] : '0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        master_valid_o = 1'b1;
        if (slave_ready_i) begin
          cnt_d   = '0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        master_valid_o = 1'b1;
        tx_addr_o      = addr_q[cnt_q];
        if (wr_q && (cnt_q < DATA_BITS)) tx_data_o = data_q[cnt_q[DIDX_W-1:0]];
        if (cnt_q == LAST_ADDR_BIT) begin
          cnt_d = '0;
          if (beats_q == '0) begin
            state_d = DONE;
          end else if (wr_q) begin
            data_req_d = 1'b1;
            state_d    = BEAT_WAIT;
          end else begin
            state_d = RD_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BEAT_WAIT: begin
        master_valid_o = 1'b1;
        if (slave_ready_i) begin
          data_d = data_in_i;
          if (beats_q != '0) beats_d = beats_q - BEAT_ONE;
          cnt_d   = '0;
          state_d = DATA;
        end
      end

      // Address is not resent: the slave auto-increments it per beat.
      DATA: begin
        master_valid_o = 1'b1;
        tx_data_o      = data_q[cnt_q[DIDX_W-1:0]];
        if (cnt_q == LAST_DATA_BIT) begin
          cnt_d = '0;
          if (beats_q == '0) begin
            state_d = DONE;
          end else begin
            data_req_d = 1'b1;
            state_d    = BEAT_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RD_HOLD: begin
        master_valid_o = 1'b1;
        if (beats_q != '0) beats_d = beats_q - BEAT_ONE;
        if (beats_q <= BEAT_ONE) state_d = DONE;
      end

      DONE: begin
        tx_done_o = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_req_o = data_req_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_master_out_port.sv
// Scoreboard bench for master_out_port: stimulus pushes per-cycle expected outputs,
// a monitor pops and compares one entry on every busy cycle.
module tb_master_out_port;

  typedef logic [4:0] exp_t; // {master_valid, tx_addr, tx_data, data_req, tx_done}

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        write_en;
  logic [11:0] addr_in;
  logic [7:0]  data_in;
  logic [12:0] burst;
  logic        slave_ready;
  logic        master_valid;
  logic        tx_addr;
  logic        tx_data;
  logic        data_req;
  logic        busy;
  logic        tx_done;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  master_out_port dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .write_en_i    (write_en),
    .addr_in_i     (addr_in),
    .data_in_i     (data_in),
    .burst_i       (burst),
    .slave_ready_i (slave_ready),
    .master_valid_o(master_valid),
    .tx_addr_o     (tx_addr),
    .tx_data_o     (tx_data),
    .data_req_o    (data_req),
    .busy_o        (busy),
    .tx_done_o     (tx_done)
  );

  task automatic monitor();
    exp_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      act = {master_valid, tx_addr, tx_data, data_req, tx_done};
      checks++;
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy_cycle t=%0t act=%b exp=<none>", $time, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t act=%b exp=%b", $time, act, e);
          end
        end
      end else if (act !== 5'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs t=%0t act=%b busy=%b exp=00000 busy=0", $time, act, busy);
      end
    end
  endtask

  // Expected cycle-by-cycle outputs from the first REQ cycle through DONE.
  task automatic push_txn(input logic [11:0] a, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input bit wr, input int extra,
                          input int req_cycles, input int limit);
    exp_t        l[$];
    logic [7:0]  bytes [3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    repeat (req_cycles) l.push_back(5'b10000);
    for (int k = 0; k < 12; k++)
      l.push_back({1'b1, a[k], (wr && k < 8) ? b0[k[2:0]] : 1'b0, 2'b00});
    if (wr) begin
      for (int b = 1; b <= extra; b++) begin
        l.push_back(5'b10010);
        for (int k = 0; k < 8; k++) l.push_back({2'b10, bytes[b][k], 2'b00});
      end
    end else begin
      repeat (extra) l.push_back(5'b10000);
    end
    l.push_back(5'b00001);
    for (int i = 0; i < l.size(); i++)
      if (limit < 0 || i < limit) exp_q.push_back(l[i]);
  endtask

  task automatic issue(input logic [11:0] a, input logic [7:0] d, input bit wr,
                       input logic [12:0] bst, input bit rdy);
    start       = 1'b1;
    addr_in     = a;
    data_in     = d;
    write_en    = wr;
    burst       = bst;
    slave_ready = rdy;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end left=%0d busy=%b exp left=0 busy=0", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic feed_beat(input logic [7:0] nxt, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_req !== 1'b1 && n < 100);
    checks++;
    if (data_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_data_req act=%b exp=1", name, data_req);
    end
    data_in = nxt;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    write_en    = 1'b0;
    addr_in     = '0;
    data_in     = '0;
    burst       = '0;
    slave_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fork
      monitor();
    join_none
    checks++;
    if ({master_valid, tx_addr, tx_data, data_req, busy, tx_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state act=%b exp=000000",
               {master_valid, tx_addr, tx_data, data_req, busy, tx_done});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single write 0xA5C / 0x3B
    push_txn(12'hA5C, 8'h3B, 8'h00, 8'h00, 1'b1, 0, 1, -1);
    issue(12'hA5C, 8'h3B, 1'b1, 13'd0, 1'b1);
    wait_idle(100, "single_write");

    // Delayed handshake: 5 REQ cycles without slave_ready
    push_txn(12'h3C7, 8'h96, 8'h00, 8'h00, 1'b1, 0, 6, -1);
    issue(12'h3C7, 8'h96, 1'b1, 13'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1 slave_ready = 1'b1;
    wait_idle(100, "delayed_hs");

    // Write burst, 2 extra beats
    push_txn(12'h040, 8'h11, 8'h22, 8'h33, 1'b1, 2, 1, -1);
    issue(12'h040, 8'h11, 1'b1, 13'b0000000000101, 1'b1);
    feed_beat(8'h22, "wburst_b1");
    feed_beat(8'h33, "wburst_b2");
    wait_idle(200, "write_burst");

    // Read burst, 3 extra beats
    push_txn(12'h7FF, 8'hAA, 8'h00, 8'h00, 1'b0, 3, 1, -1);
    issue(12'h7FF, 8'hAA, 1'b0, 13'b0000000000111, 1'b1);
    wait_idle(100, "read_burst");

    // Burst enable clear: beat count bits ignored
    push_txn(12'h001, 8'h5A, 8'h00, 8'h00, 1'b0, 0, 1, -1);
    issue(12'h001, 8'h5A, 1'b0, 13'b0000000000110, 1'b1);
    wait_idle(100, "burst_disabled");

    // Start while busy is ignored
    push_txn(12'hA5C, 8'h3B, 8'h00, 8'h00, 1'b1, 0, 1, -1);
    issue(12'hA5C, 8'h3B, 1'b1, 13'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    addr_in  = 12'h123;
    data_in  = 8'hFF;
    write_en = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(100, "start_busy");

    // Maximum read burst: 4095 extra beats
    push_txn(12'h800, 8'h00, 8'h00, 8'h00, 1'b0, 4095, 1, -1);
    issue(12'h800, 8'h00, 1'b0, {12'hFFF, 1'b1}, 1'b1);
    wait_idle(5000, "max_read_burst");

    // Reset at address bit 6
    push_txn(12'hA5C, 8'h3B, 8'h00, 8'h00, 1'b1, 0, 1, 8);
    issue(12'hA5C, 8'h3B, 1'b1, 13'd0, 1'b1);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({master_valid, busy, tx_addr, tx_data} !== 4'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset act=%b left=%0d exp=0000 left=0",
               {master_valid, busy, tx_addr, tx_data}, exp_q.size());
      exp_q.delete();
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Normal operation after reset
    push_txn(12'h5A3, 8'hC4, 8'h00, 8'h00, 1'b1, 0, 1, -1);
    issue(12'h5A3, 8'hC4, 1'b1, 13'd0, 1'b1);
    wait_idle(100, "after_reset");

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_out_port.md
# master_out_port

Master-side serializer that feeds `slave_in_port` over the serial system bus. It accepts a parallel request (12-bit address, 8-bit data, direction, burst descriptor) from the master core and raises `master_valid`. After the `master_valid`/`slave_ready` handshake it shifts the address LSB-first on `tx_addr` and, for writes, the data byte LSB-first on `tx_data`. For bursts it keeps `master_valid` high and streams additional write bytes, or holds the read burst window open, for the number of extra beats encoded in `burst`.

## Interface
- `ADDR_W`, 12, address width; fixed by bus format.
- `DATA_W`, 8, data width; fixed by bus format.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe, sampled only in IDLE.
- `write_en`  in  1  direction at `start`: 1 = write, 0 = read.
- `addr_in`  in  12  start address, latched at `start`.
- `data_in`  in  8  write byte, latched at `start` and at each later beat handshake.
- `burst`  in  13  [0] = burst enable, [12:1] = extra beats; latched at `start`.
- `slave_ready`  in  1  slave ready for a new handshake.
- `master_valid`  out  1  request valid to slave.
- `tx_addr`  out  1  serial address bit.
- `tx_data`  out  1  serial data bit.
- `data_req`  out  1  1-cycle pulse: next write byte is needed on `data_in` by the next handshake.
- `busy`  out  1  high whenever state != IDLE.
- `tx_done`  out  1  1-cycle pulse at end of transaction.

## Operation
- Reset: state IDLE; all outputs 0; shift registers, beat counter and latched fields cleared.
- IDLE: on `start`, latch `addr_in`, `data_in`, `write_en` and `burst`. Set `beats_left` = `burst[0]` ? `burst[12:1]` : 0. Go to REQ. `start` outside IDLE is ignored.
- REQ: `master_valid`=1. When `slave_ready`=1 in this state (handshake), go to ADDR.
- ADDR, 12 cycles: cycle k drives `tx_addr`=addr[k]. For writes, cycles 0..7 also drive `tx_data`=data[k]; otherwise `tx_data`=0. At the end of cycle 11:
  - if `beats_left`==0, go to DONE;
  - else for a write, pulse `data_req` and go to BEAT_WAIT;
  - else for a read, go to RD_HOLD.
- BEAT_WAIT (write burst): `master_valid` stays 1. On `slave_ready`=1, latch `data_in`, decrement `beats_left` and go to DATA.
- DATA, 8 cycles: `tx_data`=data[k]; `tx_addr`=0 (the address is not resent; the slave increments it). At the end of cycle 7:
  - if `beats_left`==0, go to DONE;
  - else pulse `data_req` and go to BEAT_WAIT.
- RD_HOLD (read burst): `master_valid`=1 for exactly `beats_left` cycles, decrementing each cycle. Go to DONE when the counter reaches 0.
- DONE: `master_valid`=0, `tx_done`=1 for one cycle, then IDLE.
- `master_valid` is 1 in REQ, ADDR, BEAT_WAIT, DATA and RD_HOLD, and 0 elsewhere. It never drops mid-transaction, because the slave treats a drop as an interrupt.
- Arithmetic: `beats_left` is 12-bit and decrements only while nonzero (no wrap). `burst[12:1]`=4095 gives 4096 total beats. With `burst[0]`=0, bits [12:1] are ignored.
- Reset mid-transaction: the transaction is abandoned and all outputs read 0 on the next cycle.

## Timing
- `start` at edge 0 → `master_valid`=1 from cycle 1.
- Handshake cycle H (REQ with `slave_ready`=1) → addr[0]/data[0] driven in cycle H+1 → addr[11] in cycle H+12.
- Single write or read: `tx_done` in cycle H+13; `busy` low and `start` accepted from cycle H+14.
- Write burst beat: `data_req` in the cycle after the last bit. Minimum BEAT_WAIT is 1 cycle, and the first bit follows the beat handshake by 1 cycle.
- Read burst: the RD_HOLD cycles immediately follow addr[11].

## Test plan
- Single write, `addr_in`=0xA5C, `data_in`=0x3B, `burst`=0, `slave_ready`=1 → over 12 cycles `tx_addr` = 0,0,1,1,1,0,1,0,0,1,0,1; `tx_data` = 1,1,0,1,1,1,0,0 then 0; `tx_done` at H+13.
- Delayed handshake: `slave_ready` held 0 for 5 cycles after `start` → `master_valid` stays 1 with no bits shifted. Shifting starts the cycle after `slave_ready` rises.
- Write burst, `burst`=13'b0000000000101 (2 extra beats), bytes 0x11, 0x22, 0x33 → 3 data bytes serialized, 2 `data_req` pulses, `master_valid` continuous, address sent once.
- Read burst, `burst`=13'b0000000000111 (3 extra beats) → `tx_data`=0 throughout; `master_valid` high for 12+3 cycles after the handshake, then `tx_done`.
- `start` pulsed while busy with different `addr_in` → ignored; the in-flight address is transmitted unchanged.
- `reset` asserted at address bit 6 → next cycle `master_valid`, `busy`, `tx_addr`, `tx_data` = 0. A new `start` after reset works normally.
